// File: rtl/dsp_peak_meter_if.sv
// rtl/dsp_peak_meter_if.sv - sample stream and result bus of the peak meter
interface dsp_peak_meter_if #(
    parameter int WS  = 16,
    parameter int CHN = 2
);
    logic [CHN*WS-1:0] iSample;
    logic              iSampleValid;
    logic [CHN*WS-1:0] oFrameMax;
    logic [CHN*WS-1:0] oPeak;
    logic [CHN-1:0]    oClip;
    logic              oValid;

    modport master (
        output iSample, iSampleValid,
        input  oFrameMax, oPeak, oClip, oValid
    );

    modport slave (
        input  iSample, iSampleValid,
        output oFrameMax, oPeak, oClip, oValid
    );
endinterface

// File: rtl/dsp_peak_meter.sv
// rtl/dsp_peak_meter.sv - per-channel frame max and display peak, framed by vsync fall
module dsp_peak_meter #(
    parameter int WS          = 16,
    parameter int CHN         = 2,
    parameter int HOLD_FRAMES = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iFrameSync,
    input  logic [1:0]       iMode,
    input  logic             iClear,
    dsp_peak_meter_if.slave  pm
);
    localparam int HC_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_FRAMES);
    localparam logic [WS-1:0]   S_MIN = {1'b1, {(WS-1){1'b0}}};
    localparam logic [WS-1:0]   S_MAX = {1'b0, {(WS-1){1'b1}}};

    typedef enum logic {HOLD = 1'b0, DECAY = 1'b1} disp_state_t;

    logic syncQ1, syncQ2, edgeQ;
    logic boundary;

    logic [WS-1:0]   accQ      [CHN];
    logic [WS-1:0]   frameMaxQ [CHN];
    logic [WS-1:0]   peakQ     [CHN];
    logic [HC_W-1:0] hcQ       [CHN];
    disp_state_t     stateQ    [CHN];
    logic [CHN-1:0]  clipAccQ;
    logic [CHN-1:0]  clipQ;
    logic            validQ;

    logic [WS-1:0]   smp       [CHN];
    logic [WS-1:0]   mag       [CHN];
    logic [WS-1:0]   frameVal  [CHN];
    logic [WS-1:0]   decayStep [CHN];
    logic [WS-1:0]   decayed   [CHN];
    logic [WS-1:0]   peakD     [CHN];
    logic [HC_W-1:0] hcD       [CHN];
    disp_state_t     stateD    [CHN];
    logic [CHN-1:0]  fullScale;
    logic [CHN-1:0]  clipFrame;

    // vsync is asynchronous; the chain keeps running through iClear
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            syncQ1 <= 1'b0;
            syncQ2 <= 1'b0;
            edgeQ  <= 1'b0;
        end else begin
            syncQ1 <= iFrameSync;
            syncQ2 <= syncQ1;
            edgeQ  <= syncQ2;
        end
    end

    assign boundary = edgeQ & ~syncQ2;

    always_comb begin
        fullScale = '0;
        clipFrame = '0;
        for (int c = 0; c < CHN; c++) begin
            smp[c] = pm.iSample[c*WS +: WS];
            if (smp[c] == S_MIN)
                mag[c] = S_MAX;
            else if (smp[c][WS-1])
                mag[c] = ~smp[c] + WS'(1);
            else
                mag[c] = smp[c];
            fullScale[c] = (smp[c] == S_MIN) || (smp[c] == S_MAX);

            // a sample landing on the boundary cycle belongs to the ending frame
            frameVal[c] = (pm.iSampleValid && (mag[c] > accQ[c])) ? mag[c] : accQ[c];
            clipFrame[c] = clipAccQ[c] | (pm.iSampleValid & fullScale[c]);

            decayStep[c] = peakQ[c] >> DECAY_SHIFT;
            if (decayStep[c] == '0)
                decayStep[c] = WS'(1);
            decayed[c] = (peakQ[c] > decayStep[c]) ? (peakQ[c] - decayStep[c]) : '0;

            peakD[c]  = peakQ[c];
            hcD[c]    = hcQ[c];
            stateD[c] = stateQ[c];
            case (iMode)
                2'd1: begin
                    if (frameVal[c] >= peakQ[c]) begin
                        peakD[c]  = frameVal[c];
                        hcD[c]    = HOLD_LOAD;
                        stateD[c] = (HOLD_FRAMES == 0) ? DECAY : HOLD;
                    end else if (stateQ[c] == HOLD) begin
                        if (hcQ[c] <= HC_W'(1)) begin
                            hcD[c]    = '0;
                            stateD[c] = DECAY;
                        end else begin
                            hcD[c] = hcQ[c] - HC_W'(1);
                        end
                    end else begin
                        peakD[c] = (frameVal[c] > decayed[c]) ? frameVal[c] : decayed[c];
                    end
                end
                2'd2: begin
                    peakD[c] = (frameVal[c] > peakQ[c]) ? frameVal[c] : peakQ[c];
                end
                default: begin
                    peakD[c]  = frameVal[c];
                    hcD[c]    = '0;
                    stateD[c] = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int c = 0; c < CHN; c++) begin
                accQ[c]      <= '0;
                frameMaxQ[c] <= '0;
                peakQ[c]     <= '0;
                hcQ[c]       <= '0;
                stateQ[c]    <= HOLD;
            end
            clipAccQ <= '0;
            clipQ    <= '0;
            validQ   <= 1'b0;
        end else if (iClear) begin
            for (int c = 0; c < CHN; c++) begin
                accQ[c]      <= '0;
                frameMaxQ[c] <= '0;
                peakQ[c]     <= '0;
                hcQ[c]       <= '0;
                stateQ[c]    <= HOLD;
            end
            clipAccQ <= '0;
            clipQ    <= '0;
            validQ   <= 1'b0;
        end else begin
            validQ <= boundary;
            if (boundary) begin
                for (int c = 0; c < CHN; c++) begin
                    accQ[c]      <= '0;
                    frameMaxQ[c] <= frameVal[c];
                    peakQ[c]     <= peakD[c];
                    hcQ[c]       <= hcD[c];
                    stateQ[c]    <= stateD[c];
                end
                clipAccQ <= '0;
                clipQ    <= (iMode == 2'd2) ? (clipQ | clipFrame) : clipFrame;
            end else if (pm.iSampleValid) begin
                for (int c = 0; c < CHN; c++) begin
                    if (mag[c] > accQ[c])
                        accQ[c] <= mag[c];
                end
                clipAccQ <= clipAccQ | fullScale;
            end
        end
    end

    always_comb begin
        pm.oFrameMax = '0;
        pm.oPeak     = '0;
        for (int c = 0; c < CHN; c++) begin
            pm.oFrameMax[c*WS +: WS] = frameMaxQ[c];
            pm.oPeak[c*WS +: WS]     = peakQ[c];
        end
    end

    assign pm.oClip  = clipQ;
    assign pm.oValid = validQ;
endmodule

// File: tb/tb_dsp_peak_meter.sv
// tb/tb_dsp_peak_meter.sv - directed scoreboard bench for dsp_peak_meter
module tb_dsp_peak_meter;
    localparam int WS  = 16;
    localparam int CHN = 2;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iFrameSync = 1'b1;
    logic       iClear = 1'b0;
    logic [1:0] iMode = 2'd0;

    dsp_peak_meter_if #(.WS(WS), .CHN(CHN)) pmIf ();

    dsp_peak_meter #(
        .WS(WS), .CHN(CHN), .HOLD_FRAMES(2), .DECAY_SHIFT(2)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .iFrameSync(iFrameSync),
        .iMode(iMode),
        .iClear(iClear),
        .pm(pmIf.slave)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [31:0] fm;
        logic [31:0] pk;
        logic [1:0]  clip;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    int   validCount = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(negedge iCLK) begin
        if (pmIf.oValid === 1'b1) begin
            validCount++;
            if (expQ.size() == 0) begin
                check("unexpected_valid", 64'(pmIf.oValid), 64'd0);
            end else begin
                monE = expQ.pop_front();
                check("frame_max", 64'(pmIf.oFrameMax), 64'(monE.fm));
                check("peak", 64'(pmIf.oPeak), 64'(monE.pk));
                check("clip", 64'(pmIf.oClip), 64'(monE.clip));
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic sample(input logic [15:0] s0, input logic [15:0] s1);
        pmIf.iSample      = {s1, s0};
        pmIf.iSampleValid = 1'b1;
        tick();
        pmIf.iSampleValid = 1'b0;
        pmIf.iSample      = '0;
    endtask

    task automatic clearAll();
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
    endtask

    // lowers vsync, optionally drives a sample on the boundary cycle, checks latency and width
    task automatic frame(input string tag, input logic [31:0] fm, input logic [31:0] pk,
                         input logic [1:0] clip, input bit coSample, input logic [31:0] coWord);
        exp_t e;
        int   n;
        bit   seen;
        e = {fm, pk, clip};
        expQ.push_back(e);
        iFrameSync = 1'b0;
        n = 0;
        seen = 1'b0;
        if (coSample) begin
            tick();
            tick();
            pmIf.iSample      = coWord;
            pmIf.iSampleValid = 1'b1;
            tick();
            pmIf.iSampleValid = 1'b0;
            pmIf.iSample      = '0;
            n = 3;
        end
        while (n < 10 && !seen) begin
            @(negedge iCLK);
            if (pmIf.oValid === 1'b1)
                seen = 1'b1;
            else begin
                @(posedge iCLK);
                n++;
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd3);
        if (!seen && expQ.size() > 0)
            void'(expQ.pop_back());
        @(posedge iCLK);
        @(negedge iCLK);
        check({tag, "_valid_width"}, 64'(pmIf.oValid), 64'd0);
        iFrameSync = 1'b1;
        tick();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        pmIf.iSample      = '0;
        pmIf.iSampleValid = 1'b0;

        // reset held: samples toggle, outputs stay zero
        repeat (3) begin
            pmIf.iSample      = {16'd1234, 16'hFFFB};
            pmIf.iSampleValid = 1'b1;
            tick();
            pmIf.iSampleValid = 1'b0;
            tick();
        end
        check("rst_frame_max", 64'(pmIf.oFrameMax), 64'd0);
        check("rst_peak", 64'(pmIf.oPeak), 64'd0);
        check("rst_clip", 64'(pmIf.oClip), 64'd0);
        check("rst_valid", 64'(pmIf.oValid), 64'd0);

        iFrameSync = 1'b0;
        tick();
        iRST_N = 1'b1;
        repeat (6) tick();
        check("no_valid_after_release", 64'(validCount), 64'd0);
        iFrameSync = 1'b1;
        repeat (4) tick();

        // mode 0
        iMode = 2'd0;
        sample(16'd100, 16'h8000);
        sample(16'hFED4, 16'd0);
        sample(16'd200, 16'd0);
        frame("m0", {16'd32767, 16'd300}, {16'd32767, 16'd300}, 2'b10, 1'b0, 32'd0);
        frame("m0_silent", 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);

        // mode 1 hold then decay
        clearAll();
        iMode = 2'd1;
        sample(16'd4000, 16'd0);
        frame("m1_f1", {16'd0, 16'd4000}, {16'd0, 16'd4000}, 2'b00, 1'b0, 32'd0);
        frame("m1_h1", 32'd0, {16'd0, 16'd4000}, 2'b00, 1'b0, 32'd0);
        frame("m1_h2", 32'd0, {16'd0, 16'd4000}, 2'b00, 1'b0, 32'd0);
        frame("m1_d1", 32'd0, {16'd0, 16'd3000}, 2'b00, 1'b0, 32'd0);
        frame("m1_d2", 32'd0, {16'd0, 16'd2250}, 2'b00, 1'b0, 32'd0);
        sample(16'd2500, 16'd0);
        frame("m1_new", {16'd0, 16'd2500}, {16'd0, 16'd2500}, 2'b00, 1'b0, 32'd0);
        frame("m1_rh1", 32'd0, {16'd0, 16'd2500}, 2'b00, 1'b0, 32'd0);
        frame("m1_rh2", 32'd0, {16'd0, 16'd2500}, 2'b00, 1'b0, 32'd0);
        frame("m1_rd1", 32'd0, {16'd0, 16'd1875}, 2'b00, 1'b0, 32'd0);

        // decay floor
        clearAll();
        sample(16'd3, 16'd0);
        frame("fl_f1", 32'd3, 32'd3, 2'b00, 1'b0, 32'd0);
        frame("fl_h1", 32'd0, 32'd3, 2'b00, 1'b0, 32'd0);
        frame("fl_h2", 32'd0, 32'd3, 2'b00, 1'b0, 32'd0);
        frame("fl_d1", 32'd0, 32'd2, 2'b00, 1'b0, 32'd0);
        frame("fl_d2", 32'd0, 32'd1, 2'b00, 1'b0, 32'd0);
        frame("fl_d3", 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);
        frame("fl_d4", 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);

        // sample coinciding with the boundary
        iMode = 2'd0;
        clearAll();
        frame("co_smp", 32'd5000, 32'd5000, 2'b00, 1'b1, 32'd5000);
        frame("co_next", 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);

        // clear coinciding with the boundary
        sample(16'd700, 16'd0);
        frame("pre_clr", 32'd700, 32'd700, 2'b00, 1'b0, 32'd0);
        sample(16'd900, 16'd0);
        vc = validCount;
        iFrameSync = 1'b0;
        tick();
        tick();
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        @(negedge iCLK);
        check("clr_frame_max", 64'(pmIf.oFrameMax), 64'd0);
        check("clr_peak", 64'(pmIf.oPeak), 64'd0);
        check("clr_clip", 64'(pmIf.oClip), 64'd0);
        repeat (5) tick();
        check("clr_no_valid", 64'(validCount - vc), 64'd0);
        iFrameSync = 1'b1;
        repeat (4) tick();
        frame("post_clr", 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);

        // mode 2 infinite hold with sticky clip
        clearAll();
        iMode = 2'd2;
        sample(16'd1000, 16'h8000);
        frame("m2_f1", {16'd32767, 16'd1000}, {16'd32767, 16'd1000}, 2'b10, 1'b0, 32'd0);
        sample(16'd500, 16'd10);
        frame("m2_f2", {16'd10, 16'd500}, {16'd32767, 16'd1000}, 2'b10, 1'b0, 32'd0);
        frame("m2_f3", 32'd0, {16'd32767, 16'd1000}, 2'b10, 1'b0, 32'd0);

        // asynchronous reset mid-frame
        sample(16'd777, 16'd0);
        @(posedge iCLK);
        #3;
        iRST_N = 1'b0;
        #1;
        check("arst_frame_max", 64'(pmIf.oFrameMax), 64'd0);
        check("arst_peak", 64'(pmIf.oPeak), 64'd0);
        check("arst_clip", 64'(pmIf.oClip), 64'd0);
        check("arst_valid", 64'(pmIf.oValid), 64'd0);
        tick();
        iRST_N = 1'b1;
        repeat (4) tick();
        frame("arst_frame", 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);

        check("queue_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_peak_meter.md
# dsp_peak_meter

Parametrised multi-channel peak meter for the audio visualisation path. It takes packed signed audio samples on a sample strobe and tracks the per-channel magnitude maximum over each video frame, with the frame delimited by the VGA vsync falling edge. Each frame it publishes the raw frame maximum and a display peak. The display peak runs in one of three modes: legacy per-frame max, hold-then-decay, or infinite hold. Outputs feed the fractal/wave visualisers and LED meters.

## Interface
- WS, 16: sample word size (signed input, unsigned magnitude output).
- CHN, 2: channel count.
- HOLD_FRAMES, 8: frames a new peak is held before decay starts (0 = decay on next frame).
- DECAY_SHIFT, 3: per-frame decay step is P >> DECAY_SHIFT, minimum 1.
- iCLK  in  1  single clock; all state on rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iSample  in  CHN*WS  signed samples; channel c at [c*WS +: WS].
- iSampleValid  in  1  one-cycle strobe, all channels sampled together.
- iFrameSync  in  1  vsync level, asynchronous to iCLK; falling edge = frame boundary.
- iMode  in  2  0 frame max, 1 hold+decay, 2 infinite hold, 3 treated as 0.
- iClear  in  1  synchronous clear of all measurement state.
- oFrameMax  out  CHN*WS  max magnitude of the last completed frame.
- oPeak  out  CHN*WS  display peak per channel.
- oClip  out  CHN  full-scale sample seen (per frame; sticky in mode 2).
- oValid  out  1  one-cycle pulse when outputs update.

## Operation
- Magnitude: |x|. The most-negative input saturates to 2^(WS-1)-1. The result is zero-extended to WS bits.
- Full-scale detect: an input equal to -2^(WS-1) or 2^(WS-1)-1 sets the channel's clip accumulator.
- Accumulator acc[c]: on iSampleValid, acc <= max(acc, mag).
- Frame boundary: iFrameSync passes through 2 synchroniser FFs and 1 edge FF (all reset to 0); boundary = edge FF & ~sync2.
- At boundary, F = max(acc, mag when iSampleValid is high in the same cycle). The coinciding sample counts toward the ending frame.
- At boundary, oFrameMax <= F, acc <= 0 (not seeded with the sample), and oClip is updated from the clip accumulator. The clip accumulator then clears, except in mode 2, where oClip ORs in.
- Per-channel display FSM, states HOLD/DECAY with counter hc (clog2(HOLD_FRAMES+1) bits). It is evaluated only at boundary, using the current iMode:
  - Mode 0: P <= F; state HOLD, hc <= 0.
  - Mode 1, F >= P: P <= F, hc <= HOLD_FRAMES. State becomes HOLD, or DECAY if HOLD_FRAMES = 0.
  - Mode 1, F < P, HOLD: hc <= hc-1 and P is unchanged. When hc reaches 0, the state goes to DECAY.
  - Mode 1, F < P, DECAY: P <= max(F, P - max(P>>DECAY_SHIFT, 1)). The subtraction saturates at 0.
  - Mode 2: P <= max(P, F); no decay.
- Mode changes take effect at the next boundary; P is not reset by a mode change.
- iClear zeroes acc, clip accumulators, oFrameMax, oPeak and oClip, and sets state HOLD with hc = 0.
  - iClear has priority over a simultaneous sample and boundary: the sample is dropped and oValid is not pulsed.
  - The synchroniser chain is not cleared.

## Timing
- Reset (async assert): all outputs 0, acc 0, FSM HOLD with hc 0, sync FFs 0. A low iFrameSync at reset release produces no boundary.
- Boundary latency:
  - iFrameSync is first sampled low at edge k.
  - Outputs update at edge k+2; oValid is high for the cycle after edge k+2.
  - Jitter vs the true vsync edge is 1 cycle.
- Sample-to-acc latency: 1 cycle. A sample is visible in oFrameMax only after the next boundary.
- At most one boundary per 3 cycles. Narrower iFrameSync low pulses (< 2 cycles) may be missed.
- Reset mid-frame discards the partial frame.

## Test plan
- Reset: hold iRST_N low, toggle samples → all outputs 0. Release with iFrameSync low → no oValid.
- Mode 0, CHN=2:
  - Stimulus: ch0 samples 100, -300, 200; ch1 -32768; then a vsync fall.
  - Required: oFrameMax = {32767, 300}, oPeak same, oClip = 2'b10.
  - oValid is exactly one cycle, 3 edges after the fall is sampled.
- Mode 1, HOLD_FRAMES=2, DECAY_SHIFT=2:
  - Frame 1 max 4000, then silent frames → P = 4000, 4000, 4000, 3000, 2250.
  - Next frame max 2500 → P = 2500 and the hold restarts: 2500 for 2 more frames.
- Decay floor: P = 3, silence, mode 1 past hold → P = 2, 1, 0, 0.
- Simultaneous events:
  - A 5000 sample coinciding with boundary → oFrameMax = 5000 and the next frame starts from 0.
  - iClear coinciding with boundary → outputs 0, no oValid.
- Mode 2 / async reset:
  - Frames with max 1000 then 500 → P stays 1000; oClip stays sticky after one full-scale frame.
  - Drop iRST_N mid-frame → all outputs 0 immediately, without waiting for a clock edge.
